// File: rtl/cache_set_assoc_pkg.sv
// Shared definitions for the set-associative cache: policy codes,
// controller state encoding and a helper for way-index width.
package cache_set_assoc_pkg;

    localparam int POLICY_FIFO = 0;
    localparam int POLICY_LRU  = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_REFILL = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    // A single-way cache still carries a 1-bit way index.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Per-set replacement state. FIFO keeps a round-robin pointer per set;
// LRU keeps an age matrix per set where row i bit j means "way i was used
// more recently than way j". The least recently used way has an all-zero row.
module cache_victim_sel
    import cache_set_assoc_pkg::*;
#(
    parameter  int SETS   = 64,
    parameter  int WAYS   = 4,
    parameter  int POLICY = POLICY_FIFO,
    localparam int IDX_W  = $clog2(SETS),
    localparam int WAY_W  = way_bits(WAYS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [IDX_W-1:0] i_set,
    input  logic [WAY_W-1:0] i_way,
    input  logic             i_touch,
    input  logic             i_fill,
    output logic [WAY_W-1:0] o_victim
);

    if (WAYS == 1) begin : g_direct
        logic w_unused_in;
        assign w_unused_in = ^{i_clk, i_reset, i_set, i_way, i_touch, i_fill};
        assign o_victim    = '0;
    end else if (POLICY == POLICY_LRU) begin : g_lru
        logic [WAYS-1:0] r_age [SETS][WAYS];

        // Lowest-numbered way with an all-zero row is the LRU way.
        always_comb begin
            o_victim = '0;
            for (int i = WAYS - 1; i >= 0; i--) begin
                if (r_age[i_set][i] == '0) o_victim = WAY_W'(i);
            end
        end

        // Touched way becomes MRU: its row fills with ones, its column clears.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int s = 0; s < SETS; s++)
                    for (int i = 0; i < WAYS; i++)
                        r_age[s][i] <= '0;
            end else if (i_touch || i_fill) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (i == int'(i_way)) r_age[i_set][i] <= ~(WAYS'(1) << i);
                    else                  r_age[i_set][i][i_way] <= 1'b0;
                end
            end
        end
    end else begin : g_fifo
        logic [WAY_W-1:0] r_ptr [SETS];
        logic             w_unused_in;

        assign w_unused_in = i_touch ^ (^i_way);
        assign o_victim    = r_ptr[i_set];

        // Pointer advances on every refill; WAYS is a power of two so it wraps.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
            end else if (i_fill) begin
                r_ptr[i_set] <= r_ptr[i_set] + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/cache_set_assoc.sv
// N-way set-associative write-back, write-allocate data cache, one word per
// line. Handshakes: a request/transfer completes in the cycle its valid and
// ready are both high; a valid stays up with its payload stable until then,
// and a ready seen without its valid is ignored.
module cache_set_assoc
    import cache_set_assoc_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int WAYS   = 4,
    parameter int POLICY = POLICY_FIFO
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        rc_Valid,
    input  logic        rc_RW,
    input  logic [31:0] rc_Addr,
    input  logic [31:0] rc_WriteData,
    input  logic        rc_Flush,
    output logic        rc_Ready,
    output logic        rc_Hit,
    output logic [31:0] rc_ReadData,
    output logic        rc_Busy,
    output logic        cm_ReadValid,
    output logic [31:0] cm_ReadAddr,
    input  logic        cm_ReadReady,
    input  logic [31:0] cm_ReadData,
    output logic        cm_WriteValid,
    output logic [31:0] cm_WriteAddr,
    output logic [31:0] cm_WriteData,
    input  logic        cm_WriteReady,
    output state_t      dbg_State
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = way_bits(WAYS);
    localparam int TAG_W = 30 - IDX_W;

    logic [WAYS-1:0]  r_valid [SETS];
    logic [WAYS-1:0]  r_dirty [SETS];
    logic [TAG_W-1:0] r_tag   [SETS][WAYS];
    logic [31:0]      r_data  [SETS][WAYS];
    state_t           r_state;
    logic [WAY_W-1:0] r_vway;
    logic [IDX_W-1:0] r_fset;
    logic [WAY_W-1:0] r_fway;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit_any;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_inv_any;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_pol_way;
    logic [WAY_W-1:0] w_miss_way;
    logic [WAY_W-1:0] w_upd_way;
    logic             w_fill;
    logic             w_fdirty;
    logic             w_flast;
    logic             w_unused_addr;

    assign w_idx         = rc_Addr[IDX_W+1:2];
    assign w_tag         = rc_Addr[31:IDX_W+2];
    assign w_unused_addr = ^rc_Addr[1:0];
    assign w_miss_way    = w_inv_any ? w_inv_way : w_pol_way;
    assign w_fill        = (r_state == ST_REFILL) && cm_ReadReady;
    assign w_upd_way     = (r_state == ST_REFILL) ? r_vway : w_hit_way;
    assign w_fdirty      = r_dirty[r_fset][r_fway];
    assign w_flast       = (r_fset == IDX_W'(SETS - 1)) && (r_fway == WAY_W'(WAYS - 1));
    assign dbg_State     = r_state;

    // Tag lookup in the addressed set; also find the lowest invalid way.
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_inv_any = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
    end

    cache_victim_sel #(
        .SETS   (SETS),
        .WAYS   (WAYS),
        .POLICY (POLICY)
    ) u_victim (
        .i_clk    (CLK),
        .i_reset  (Reset),
        .i_set    (w_idx),
        .i_way    (w_upd_way),
        .i_touch  (rc_Ready),
        .i_fill   (w_fill),
        .o_victim (w_pol_way)
    );

    // Core- and memory-side outputs, decoded from the state; payloads are 0 when idle.
    always_comb begin
        rc_Hit        = rc_Valid && w_hit_any;
        rc_Ready      = (r_state == ST_IDLE) && rc_Valid && w_hit_any;
        rc_ReadData   = (rc_Ready && !rc_RW) ? r_data[w_idx][w_hit_way] : '0;
        rc_Busy       = (r_state == ST_FLUSH);
        cm_ReadValid  = (r_state == ST_REFILL);
        cm_ReadAddr   = cm_ReadValid ? {rc_Addr[31:2], 2'b00} : '0;
        cm_WriteValid = 1'b0;
        cm_WriteAddr  = '0;
        cm_WriteData  = '0;
        if (r_state == ST_WB) begin
            cm_WriteValid = 1'b1;
            cm_WriteAddr  = {r_tag[w_idx][r_vway], w_idx, 2'b00};
            cm_WriteData  = r_data[w_idx][r_vway];
        end else if ((r_state == ST_FLUSH) && w_fdirty) begin
            cm_WriteValid = 1'b1;
            cm_WriteAddr  = {r_tag[r_fset][r_fway], r_fset, 2'b00};
            cm_WriteData  = r_data[r_fset][r_fway];
        end
    end

    // Controller and line arrays; an aborted miss or flush leaves V/D untouched.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_vway  <= '0;
            r_fset  <= '0;
            r_fway  <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rc_Valid) begin
                        if (w_hit_any) begin
                            if (rc_RW) begin
                                r_data[w_idx][w_hit_way]  <= rc_WriteData;
                                r_dirty[w_idx][w_hit_way] <= 1'b1;
                            end
                        end else begin
                            r_vway  <= w_miss_way;
                            r_state <= (r_valid[w_idx][w_miss_way] && r_dirty[w_idx][w_miss_way])
                                       ? ST_WB : ST_REFILL;
                        end
                    end else if (rc_Flush) begin
                        r_fset  <= '0;
                        r_fway  <= '0;
                        r_state <= ST_FLUSH;
                    end
                end
                ST_WB: begin
                    if (cm_WriteReady) begin
                        r_dirty[w_idx][r_vway] <= 1'b0;
                        r_state                <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (cm_ReadReady) begin
                        r_tag[w_idx][r_vway]   <= w_tag;
                        r_data[w_idx][r_vway]  <= cm_ReadData;
                        r_valid[w_idx][r_vway] <= 1'b1;
                        r_dirty[w_idx][r_vway] <= 1'b0;
                        r_state                <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (!w_fdirty || cm_WriteReady) begin
                        r_dirty[r_fset][r_fway] <= 1'b0;
                        if (w_flast) begin
                            r_state <= ST_IDLE;
                        end else if (r_fway == WAY_W'(WAYS - 1)) begin
                            r_fway <= '0;
                            r_fset <= r_fset + IDX_W'(1);
                        end else begin
                            r_fway <= r_fway + WAY_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_set_assoc.sv
// Bench for cache_set_assoc: a FIFO instance (64 sets x 4 ways) and an LRU
// instance (4 sets x 4 ways) share the stimulus bus; sel picks which one the
// core/memory driver talks to. A line-level reference model predicts every
// hit, victim, write-back and returned word.
module tb_cache_set_assoc;
    import cache_set_assoc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        rc_valid, rc_rw, rc_flush;
    logic [31:0] rc_addr, rc_wdata;
    logic        cm_rready, cm_wready;
    logic [31:0] cm_rdata;

    logic        f_ready, f_hit, f_busy, f_rvalid, f_wvalid;
    logic [31:0] f_rdata, f_raddr, f_waddr, f_wdata;
    state_t      f_state;
    logic        l_ready, l_hit, l_busy, l_rvalid, l_wvalid;
    logic [31:0] l_rdata, l_raddr, l_waddr, l_wdata;
    state_t      l_state;

    logic        o_ready, o_hit, o_busy, o_rvalid, o_wvalid;
    logic [31:0] o_rdata, o_raddr, o_waddr, o_wdata;
    state_t      o_state;

    int n_checks = 0;
    int n_errors = 0;
    int wb_seen  = 0;

    // Reference model: per instance, set, way.
    bit          m_v   [2][64][4];
    bit          m_d   [2][64][4];
    logic [29:0] m_la  [2][64][4];
    logic [31:0] m_dat [2][64][4];
    int          m_ptr [2][64];
    int          m_lru [2][64][$];
    logic [31:0] mem   [bit [32:0]];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    cache_set_assoc #(.SETS(64), .WAYS(4), .POLICY(POLICY_FIFO)) dut (
        .CLK(clk), .Reset(rst),
        .rc_Valid(rc_valid && !sel), .rc_RW(rc_rw), .rc_Addr(rc_addr),
        .rc_WriteData(rc_wdata), .rc_Flush(rc_flush && !sel),
        .rc_Ready(f_ready), .rc_Hit(f_hit), .rc_ReadData(f_rdata), .rc_Busy(f_busy),
        .cm_ReadValid(f_rvalid), .cm_ReadAddr(f_raddr), .cm_ReadReady(cm_rready),
        .cm_ReadData(cm_rdata), .cm_WriteValid(f_wvalid), .cm_WriteAddr(f_waddr),
        .cm_WriteData(f_wdata), .cm_WriteReady(cm_wready), .dbg_State(f_state)
    );

    cache_set_assoc #(.SETS(4), .WAYS(4), .POLICY(POLICY_LRU)) dut_lru (
        .CLK(clk), .Reset(rst),
        .rc_Valid(rc_valid && sel), .rc_RW(rc_rw), .rc_Addr(rc_addr),
        .rc_WriteData(rc_wdata), .rc_Flush(rc_flush && sel),
        .rc_Ready(l_ready), .rc_Hit(l_hit), .rc_ReadData(l_rdata), .rc_Busy(l_busy),
        .cm_ReadValid(l_rvalid), .cm_ReadAddr(l_raddr), .cm_ReadReady(cm_rready),
        .cm_ReadData(cm_rdata), .cm_WriteValid(l_wvalid), .cm_WriteAddr(l_waddr),
        .cm_WriteData(l_wdata), .cm_WriteReady(cm_wready), .dbg_State(l_state)
    );

    assign o_ready  = sel ? l_ready  : f_ready;
    assign o_hit    = sel ? l_hit    : f_hit;
    assign o_busy   = sel ? l_busy   : f_busy;
    assign o_rvalid = sel ? l_rvalid : f_rvalid;
    assign o_wvalid = sel ? l_wvalid : f_wvalid;
    assign o_rdata  = sel ? l_rdata  : f_rdata;
    assign o_raddr  = sel ? l_raddr  : f_raddr;
    assign o_waddr  = sel ? l_waddr  : f_waddr;
    assign o_wdata  = sel ? l_wdata  : f_wdata;
    assign o_state  = sel ? l_state  : f_state;

    // Count accepted write-backs of the selected instance.
    always @(negedge clk) if (o_wvalid && cm_wready) wb_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_sets(input int s);
        return (s != 0) ? 4 : 64;
    endfunction

    function automatic logic [31:0] mem_get(input int s, input logic [31:0] a);
        bit [32:0] k;
        k = {s[0], a};
        if (mem.exists(k)) return mem[k];
        return {a[15:0] ^ 16'hC3A5, a[17:2]} ^ ((s != 0) ? 32'h0F0F_0000 : 32'h0);
    endfunction

    function automatic void mem_put(input int s, input logic [31:0] a, input logic [31:0] d);
        bit [32:0] k;
        k = {s[0], a};
        mem[k] = d;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++)
            for (int st = 0; st < 64; st++) begin
                m_ptr[s][st] = 0;
                m_lru[s][st].delete();
                for (int w = 0; w < 4; w++) begin
                    m_v[s][st][w] = 0;
                    m_d[s][st][w] = 0;
                    m_lru[s][st].push_back(w);
                end
            end
    endfunction

    // Move a way to the most-recently-used end of the set's order list.
    function automatic void lru_use(input int s, input int st, input int w);
        for (int i = 0; i < m_lru[s][st].size(); i++)
            if (m_lru[s][st][i] == w) begin
                m_lru[s][st].delete(i);
                break;
            end
        m_lru[s][st].push_back(w);
    endfunction

    task automatic do_reset();
        rst = 1'b1; rc_valid = 1'b0; rc_flush = 1'b0;
        cm_rready = 1'b0; cm_wready = 1'b0; cm_rdata = '0;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // One core access, driven from posedge+1 and returning at posedge+1.
    // wbw/rdw: memory wait cycles before ready (-1 = random).
    task automatic access(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                          input int wbw, input int rdw);
        int          s, st, hw, vw, wt;
        logic [29:0] la;
        logic [31:0] ea, ed;
        s  = int'(sel);
        la = addr[31:2];
        st = int'(la % n_sets(s));
        hw = -1;
        for (int w = 0; w < 4; w++) if (m_v[s][st][w] && m_la[s][st][w] == la) hw = w;
        rc_valid = 1'b1; rc_rw = rw; rc_addr = addr; rc_wdata = wd;
        if (hw < 0) begin
            vw = -1;
            for (int w = 3; w >= 0; w--) if (!m_v[s][st][w]) vw = w;
            if (vw < 0) vw = (s != 0) ? m_lru[s][st][0] : m_ptr[s][st];
            @(negedge clk);
            chk("miss_hit", 32'(o_hit), 32'd0);
            chk("miss_ready", 32'(o_ready), 32'd0);
            chk("miss_no_cm", 32'({o_rvalid, o_wvalid}), 32'd0);
            step();
            if (m_v[s][st][vw] && m_d[s][st][vw]) begin
                ea = {m_la[s][st][vw], 2'b00};
                ed = m_dat[s][st][vw];
                wt = (wbw < 0) ? int'($urandom_range(0, 3)) : wbw;
                repeat (wt) begin
                    @(negedge clk);
                    chk("wb_valid", 32'(o_wvalid), 32'd1);
                    chk("wb_addr", o_waddr, ea);
                    chk("wb_data", o_wdata, ed);
                    chk("wb_no_read", 32'(o_rvalid), 32'd0);
                    step();
                end
                cm_wready = 1'b1;
                @(negedge clk);
                chk("wb_valid", 32'(o_wvalid), 32'd1);
                chk("wb_addr", o_waddr, ea);
                chk("wb_data", o_wdata, ed);
                step();
                cm_wready = 1'b0;
                mem_put(s, ea, ed);
                m_d[s][st][vw] = 0;
            end
            wt = (rdw < 0) ? int'($urandom_range(0, 3)) : rdw;
            repeat (wt) begin
                @(negedge clk);
                chk("rf_valid", 32'(o_rvalid), 32'd1);
                chk("rf_addr", o_raddr, {addr[31:2], 2'b00});
                chk("rf_no_write", 32'(o_wvalid), 32'd0);
                step();
            end
            cm_rready = 1'b1;
            cm_rdata  = mem_get(s, {addr[31:2], 2'b00});
            @(negedge clk);
            chk("rf_valid", 32'(o_rvalid), 32'd1);
            chk("rf_addr", o_raddr, {addr[31:2], 2'b00});
            chk("rf_not_ready", 32'(o_ready), 32'd0);
            step();
            cm_rready = 1'b0;
            m_v[s][st][vw]   = 1;
            m_d[s][st][vw]   = 0;
            m_la[s][st][vw]  = la;
            m_dat[s][st][vw] = cm_rdata;
            cm_rdata         = '0;
            m_ptr[s][st]     = (m_ptr[s][st] + 1) % 4;
            lru_use(s, st, vw);
            hw = vw;
        end
        @(negedge clk);
        chk("hit_flag", 32'(o_hit), 32'd1);
        chk("hit_ready", 32'(o_ready), 32'd1);
        chk("hit_no_cm", 32'({o_rvalid, o_wvalid}), 32'd0);
        chk("hit_rdata", o_rdata, rw ? 32'd0 : m_dat[s][st][hw]);
        step();
        rc_valid = 1'b0;
        if (rw) begin
            m_dat[s][st][hw] = wd;
            m_d[s][st][hw]   = 1;
        end
        lru_use(s, st, hw);
    endtask

    // Flush walk: every line costs one cycle, dirty lines wait for the write ack.
    task automatic do_flush();
        int          s, base, n, wt;
        logic [31:0] ea, ed;
        s = int'(sel);
        exp_q.delete();
        for (int st = 0; st < n_sets(s); st++)
            for (int w = 0; w < 4; w++)
                if (m_d[s][st][w]) exp_q.push_back({m_la[s][st][w], 2'b00});
        n = exp_q.size();
        base = wb_seen;
        rc_flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_pre", 32'(o_busy), 32'd0);
        step();
        rc_flush = 1'b0;
        for (int st = 0; st < n_sets(s); st++)
            for (int w = 0; w < 4; w++) begin
                if (m_d[s][st][w]) begin
                    ea = exp_q.pop_front();
                    ed = m_dat[s][st][w];
                    wt = int'($urandom_range(0, 2));
                    repeat (wt) begin
                        @(negedge clk);
                        chk("flush_busy", 32'(o_busy), 32'd1);
                        chk("flush_wvalid", 32'(o_wvalid), 32'd1);
                        chk("flush_waddr", o_waddr, ea);
                        chk("flush_wdata", o_wdata, ed);
                        step();
                    end
                    cm_wready = 1'b1;
                    @(negedge clk);
                    chk("flush_wvalid", 32'(o_wvalid), 32'd1);
                    chk("flush_waddr", o_waddr, ea);
                    chk("flush_wdata", o_wdata, ed);
                    step();
                    cm_wready = 1'b0;
                    mem_put(s, ea, ed);
                    m_d[s][st][w] = 0;
                end else begin
                    @(negedge clk);
                    chk("flush_busy", 32'(o_busy), 32'd1);
                    chk("flush_skip", 32'(o_wvalid), 32'd0);
                    step();
                end
            end
        @(negedge clk);
        chk("flush_done_busy", 32'(o_busy), 32'd0);
        chk("flush_done_state", 32'(o_state), 32'(ST_IDLE));
        chk("flush_wb_count", 32'(wb_seen - base), 32'(n));
        step();
    endtask

    task automatic rand_phase(input int count);
        int          sp[4];
        int          tp[6];
        int          s, st, tg;
        logic [31:0] a;
        sp = '{0, 1, 3, 63};
        tp = '{0, 1, 2, 3, 5, 'h3FFF};
        s  = int'(sel);
        for (int i = 0; i < count; i++) begin
            st = (s != 0) ? int'($urandom_range(0, 3)) : sp[$urandom_range(0, 3)];
            tg = tp[$urandom_range(0, 5)];
            a  = 32'((tg * n_sets(s) + st) * 4) | 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), a, $urandom, -1, -1);
        end
    endtask

    initial begin
        sel = 1'b0; rc_rw = 1'b0; rc_addr = '0; rc_wdata = '0;
        do_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_state", 32'(o_state), 32'(ST_IDLE));
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cm_valid", 32'({o_rvalid, o_wvalid}), 32'd0);
        chk("rst_raddr", o_raddr, 32'd0);
        chk("rst_waddr", o_waddr, 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        step();

        // First miss, then write hit and read hit.
        mem_put(0, 32'h100, 32'hCAFE_0001);
        access(1'b0, 32'h100, 32'h0, -1, 2);
        access(1'b1, 32'h100, 32'h1234_5678, -1, -1);
        access(1'b0, 32'h100, 32'h0, -1, -1);

        // FIFO eviction in set 0 with way 0 dirty; write-back held 3 cycles.
        do_reset();
        access(1'b1, 32'h000, 32'hA0A0_0000, -1, -1);
        access(1'b0, 32'h100, 32'h0, -1, -1);
        access(1'b0, 32'h200, 32'h0, -1, -1);
        access(1'b0, 32'h300, 32'h0, -1, -1);
        access(1'b0, 32'h400, 32'h0, 3, 1);
        access(1'b0, 32'h000, 32'h0, -1, -1);

        // Flush with dirty lines in sets 3 and 63 only.
        do_reset();
        access(1'b1, 32'h00C, 32'h3333_0003, -1, -1);
        access(1'b1, 32'h0FC, 32'h6363_003F, -1, -1);
        do_flush();
        access(1'b0, 32'h00C, 32'h0, -1, -1);
        access(1'b0, 32'h0FC, 32'h0, -1, -1);

        // Flush pulse together with a request is ignored.
        rc_flush = 1'b1;
        access(1'b0, 32'h00C, 32'h0, -1, -1);
        rc_flush = 1'b0;
        @(negedge clk);
        chk("flush_ignored", 32'(o_busy), 32'd0);
        step();

        // Randomised traffic on the FIFO instance, then a full flush.
        rand_phase(150);
        do_flush();

        // LRU instance: A,B,C,D, touch A, miss on E evicts B.
        sel = 1'b1;
        access(1'b0, 32'h000, 32'h0, -1, -1);
        access(1'b0, 32'h010, 32'h0, -1, -1);
        access(1'b0, 32'h020, 32'h0, -1, -1);
        access(1'b0, 32'h030, 32'h0, -1, -1);
        access(1'b0, 32'h000, 32'h0, -1, -1);
        access(1'b0, 32'h040, 32'h0, -1, -1);
        access(1'b0, 32'h000, 32'h0, -1, -1);
        access(1'b0, 32'h010, 32'h0, -1, -1);
        rand_phase(150);
        do_flush();

        // Reset in the middle of a refill.
        sel = 1'b0;
        rc_valid = 1'b1; rc_rw = 1'b0; rc_addr = 32'h500;
        @(negedge clk);
        chk("abort_miss", 32'(o_hit), 32'd0);
        step();
        @(negedge clk);
        chk("abort_refill", 32'(o_rvalid), 32'd1);
        rst = 1'b1; rc_valid = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_state", 32'(o_state), 32'(ST_IDLE));
        chk("abort_cm_valid", 32'({o_rvalid, o_wvalid}), 32'd0);
        chk("abort_raddr", o_raddr, 32'd0);
        chk("abort_ready_busy", 32'({o_ready, o_busy}), 32'd0);
        step();
        access(1'b0, 32'h500, 32'h0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
